// File: rtl/gpu_mem_pkg.sv
// Shared types for the data-memory channel controller: posted-write entry
// layout and the memory-side state encoding.
package gpu_mem_pkg;

    localparam int PKG_ADDR_BITS = 8;
    localparam int PKG_DATA_BITS = 8;

    typedef struct packed {
        logic [PKG_ADDR_BITS-1:0] addr;
        logic [PKG_DATA_BITS-1:0] data;
    } wbuf_entry_t;

    typedef enum logic [1:0] {
        M_IDLE  = 2'd0,
        M_READ  = 2'd1,
        M_WRITE = 2'd2,
        M_RESP  = 2'd3
    } mem_state_t;

endpackage

// File: rtl/dmem_channel_ctrl_if.sv
// Cache-side and memory-side handshake bundle of the data-memory channel.
// The controller takes the slave view; the cache/memory environment the master view.
interface dmem_channel_ctrl_if #(
    parameter int ADDR_BITS  = 8,
    parameter int DATA_BITS  = 8,
    parameter int WBUF_DEPTH = 4
);
    localparam int CNT_BITS = $clog2(WBUF_DEPTH) + 1;

    logic                 up_read_valid;
    logic [ADDR_BITS-1:0] up_read_address;
    logic                 up_read_ready;
    logic [DATA_BITS-1:0] up_read_data;

    logic                 up_write_valid;
    logic [ADDR_BITS-1:0] up_write_address;
    logic [DATA_BITS-1:0] up_write_data;
    logic                 up_write_ready;

    logic                 mem_read_valid;
    logic [ADDR_BITS-1:0] mem_read_address;
    logic                 mem_read_ready;
    logic [DATA_BITS-1:0] mem_read_data;

    logic                 mem_write_valid;
    logic [ADDR_BITS-1:0] mem_write_address;
    logic [DATA_BITS-1:0] mem_write_data;
    logic                 mem_write_ready;

    logic [CNT_BITS-1:0]  wbuf_count;

    modport slave (
        input  up_read_valid, up_read_address,
        input  up_write_valid, up_write_address, up_write_data,
        input  mem_read_ready, mem_read_data, mem_write_ready,
        output up_read_ready, up_read_data, up_write_ready,
        output mem_read_valid, mem_read_address,
        output mem_write_valid, mem_write_address, mem_write_data,
        output wbuf_count
    );

    modport master (
        output up_read_valid, up_read_address,
        output up_write_valid, up_write_address, up_write_data,
        output mem_read_ready, mem_read_data, mem_write_ready,
        input  up_read_ready, up_read_data, up_write_ready,
        input  mem_read_valid, mem_read_address,
        input  mem_write_valid, mem_write_address, mem_write_data,
        input  wbuf_count
    );

endinterface

// File: rtl/post_write_buffer.sv
// Posted-write FIFO with a parallel address search that returns the data of
// the youngest live entry matching the lookup address.
module post_write_buffer
    import gpu_mem_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int ADDR_BITS = PKG_ADDR_BITS,
    parameter int DATA_BITS = PKG_DATA_BITS
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          push,
    input  wbuf_entry_t                   push_entry,
    input  logic                          pop,
    output wbuf_entry_t                   head,
    output logic [$clog2(DEPTH):0]        count,
    output logic                          full,
    output logic                          empty,
    input  logic [ADDR_BITS-1:0]          lookup_addr,
    output logic                          hit,
    output logic [DATA_BITS-1:0]          hit_data
);
    localparam int PTR_BITS = $clog2(DEPTH);
    localparam int CNT_BITS = PTR_BITS + 1;

    wbuf_entry_t         storage [DEPTH];
    logic [PTR_BITS-1:0] head_reg;
    logic [PTR_BITS-1:0] tail_reg;
    logic [CNT_BITS-1:0] count_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            if (push) begin
                tail_reg <= tail_reg + 1'b1;
            end
            if (pop) begin
                head_reg <= head_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Payload needs no reset: only slots below count are ever looked at.
    always_ff @(posedge clk) begin
        if (push) begin
            storage[tail_reg] <= push_entry;
        end
    end

    assign head  = storage[head_reg];
    assign count = count_reg;
    assign full  = (count_reg == CNT_BITS'(DEPTH));
    assign empty = (count_reg == '0);

    // Age index gi: 0 is the oldest live entry, count-1 the youngest.
    logic [DEPTH-1:0] match;
    wbuf_entry_t      aged_entry [DEPTH];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_age
            logic [PTR_BITS-1:0] slot;
            assign slot           = head_reg + PTR_BITS'(gi);
            assign aged_entry[gi] = storage[slot];
            assign match[gi]      = (CNT_BITS'(gi) < count_reg) &&
                                    (storage[slot].addr == lookup_addr);
        end
    endgenerate

    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (match[i]) begin
                hit      = 1'b1;
                hit_data = aged_entry[i].data;
            end
        end
    end

endmodule

// File: rtl/dmem_channel_ctrl.sv
// Data-memory channel controller: posts write-through stores with an early ack,
// services read misses ahead of draining, and forwards reads from posted writes.
module dmem_channel_ctrl
    import gpu_mem_pkg::*;
#(
    parameter int ADDR_BITS  = PKG_ADDR_BITS,
    parameter int DATA_BITS  = PKG_DATA_BITS,
    parameter int WBUF_DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    dmem_channel_ctrl_if.slave bus
);
    localparam int CNT_BITS = $clog2(WBUF_DEPTH) + 1;

    mem_state_t           state_reg, state_next;
    logic                 up_read_ready_reg, up_read_ready_next;
    logic [DATA_BITS-1:0] up_read_data_reg, up_read_data_next;
    logic                 up_write_ready_reg;
    logic                 mem_read_valid_reg, mem_read_valid_next;
    logic [ADDR_BITS-1:0] mem_read_address_reg, mem_read_address_next;
    logic                 mem_write_valid_reg, mem_write_valid_next;
    logic [ADDR_BITS-1:0] mem_write_address_reg, mem_write_address_next;
    logic [DATA_BITS-1:0] mem_write_data_reg, mem_write_data_next;
    logic [DATA_BITS-1:0] resp_data_reg, resp_data_next;

    logic                 push;
    logic                 pop;
    logic                 read_eligible;
    logic                 wbuf_full;
    logic                 wbuf_empty;
    logic                 fwd_hit;
    logic [DATA_BITS-1:0] fwd_data;
    logic [CNT_BITS-1:0]  wbuf_count;
    wbuf_entry_t          head_entry;
    wbuf_entry_t          push_entry;

    // A ready register still high means the requester has not yet dropped
    // valid, so that channel is in cooldown for this cycle.
    assign pop           = (state_reg == M_WRITE) && bus.mem_write_ready;
    assign push          = bus.up_write_valid && !up_write_ready_reg && (!wbuf_full || pop);
    assign read_eligible = bus.up_read_valid && !up_read_ready_reg && !push;

    assign push_entry.addr = bus.up_write_address;
    assign push_entry.data = bus.up_write_data;

    post_write_buffer #(
        .DEPTH     (WBUF_DEPTH),
        .ADDR_BITS (ADDR_BITS),
        .DATA_BITS (DATA_BITS)
    ) u_wbuf (
        .clk         (clk),
        .reset       (reset),
        .push        (push),
        .push_entry  (push_entry),
        .pop         (pop),
        .head        (head_entry),
        .count       (wbuf_count),
        .full        (wbuf_full),
        .empty       (wbuf_empty),
        .lookup_addr (bus.up_read_address),
        .hit         (fwd_hit),
        .hit_data    (fwd_data)
    );

    always_comb begin
        state_next             = state_reg;
        up_read_ready_next     = 1'b0;
        up_read_data_next      = up_read_data_reg;
        mem_read_valid_next    = mem_read_valid_reg;
        mem_read_address_next  = mem_read_address_reg;
        mem_write_valid_next   = mem_write_valid_reg;
        mem_write_address_next = mem_write_address_reg;
        mem_write_data_next    = mem_write_data_reg;
        resp_data_next         = resp_data_reg;

        case (state_reg)
            M_IDLE: begin
                if (read_eligible) begin
                    if (fwd_hit) begin
                        resp_data_next = fwd_data;
                        state_next     = M_RESP;
                    end else begin
                        mem_read_valid_next   = 1'b1;
                        mem_read_address_next = bus.up_read_address;
                        state_next            = M_READ;
                    end
                end else if (!wbuf_empty) begin
                    mem_write_valid_next   = 1'b1;
                    mem_write_address_next = head_entry.addr;
                    mem_write_data_next    = head_entry.data;
                    state_next             = M_WRITE;
                end
            end
            M_READ: begin
                if (bus.mem_read_ready) begin
                    resp_data_next      = bus.mem_read_data;
                    mem_read_valid_next = 1'b0;
                    state_next          = M_RESP;
                end
            end
            M_WRITE: begin
                if (bus.mem_write_ready) begin
                    mem_write_valid_next = 1'b0;
                    state_next           = M_IDLE;
                end
            end
            M_RESP: begin
                up_read_ready_next = 1'b1;
                up_read_data_next  = resp_data_reg;
                state_next         = M_IDLE;
            end
            default: state_next = M_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg             <= M_IDLE;
            up_read_ready_reg     <= 1'b0;
            up_read_data_reg      <= '0;
            up_write_ready_reg    <= 1'b0;
            mem_read_valid_reg    <= 1'b0;
            mem_read_address_reg  <= '0;
            mem_write_valid_reg   <= 1'b0;
            mem_write_address_reg <= '0;
            mem_write_data_reg    <= '0;
            resp_data_reg         <= '0;
        end else begin
            state_reg             <= state_next;
            up_read_ready_reg     <= up_read_ready_next;
            up_read_data_reg      <= up_read_data_next;
            up_write_ready_reg    <= push;
            mem_read_valid_reg    <= mem_read_valid_next;
            mem_read_address_reg  <= mem_read_address_next;
            mem_write_valid_reg   <= mem_write_valid_next;
            mem_write_address_reg <= mem_write_address_next;
            mem_write_data_reg    <= mem_write_data_next;
            resp_data_reg         <= resp_data_next;
        end
    end

    assign bus.up_read_ready     = up_read_ready_reg;
    assign bus.up_read_data      = up_read_data_reg;
    assign bus.up_write_ready    = up_write_ready_reg;
    assign bus.mem_read_valid    = mem_read_valid_reg;
    assign bus.mem_read_address  = mem_read_address_reg;
    assign bus.mem_write_valid   = mem_write_valid_reg;
    assign bus.mem_write_address = mem_write_address_reg;
    assign bus.mem_write_data    = mem_write_data_reg;
    assign bus.wbuf_count        = wbuf_count;

endmodule

// File: tb/tb_dmem_channel_ctrl.sv
// Directed bench for dmem_channel_ctrl: a per-cycle vector table for the basic
// write/read/collision flows plus hand-written multi-cycle corner sequences.
`timescale 1ns/1ps
module tb_dmem_channel_ctrl;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    dmem_channel_ctrl_if #(.ADDR_BITS(8), .DATA_BITS(8), .WBUF_DEPTH(4)) bus ();

    dmem_channel_ctrl #(.ADDR_BITS(8), .DATA_BITS(8), .WBUF_DEPTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Per-cycle record: inputs driven before an edge, outputs expected just after it.
    // exp packing: {urr, urd[8], uwr, mrv, mra[8], mwv, mwa[8], mwd[8], cnt[3]}
    typedef struct {
        logic        rv;
        logic [7:0]  ra;
        logic        wv;
        logic [7:0]  wa;
        logic [7:0]  wd;
        logic        mrr;
        logic [7:0]  mrd;
        logic        mwr;
        logic [38:0] exp;
    } vec_t;

    vec_t vecs[$];

    logic [15:0] mem_wr_log[$];
    int          mrv_cycles = 0;
    int          peak_count = 0;

    always @(posedge clk) begin
        if (!reset) begin
            if (bus.mem_write_valid && bus.mem_write_ready)
                mem_wr_log.push_back({bus.mem_write_address, bus.mem_write_data});
            if (bus.mem_read_valid)
                mrv_cycles++;
            if (int'(bus.wbuf_count) > peak_count)
                peak_count = int'(bus.wbuf_count);
            if (bus.mem_read_valid && bus.mem_write_valid) begin
                miscompares++;
                $display("FAIL mem_valid_exclusive: got both valids 1, want at most one");
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, want finished");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [38:0] outs();
        return {bus.up_read_ready, bus.up_read_data, bus.up_write_ready,
                bus.mem_read_valid, bus.mem_read_address,
                bus.mem_write_valid, bus.mem_write_address, bus.mem_write_data,
                bus.wbuf_count};
    endfunction

    function automatic void add(
        input logic rv, input logic [7:0] ra,
        input logic wv, input logic [7:0] wa, input logic [7:0] wd,
        input logic mrr, input logic [7:0] mrd, input logic mwr,
        input logic urr, input logic [7:0] urd, input logic uwr,
        input logic mrv, input logic [7:0] mra,
        input logic mwv, input logic [7:0] mwa, input logic [7:0] mwd,
        input logic [2:0] cnt);
        vec_t v;
        v.rv = rv; v.ra = ra; v.wv = wv; v.wa = wa; v.wd = wd;
        v.mrr = mrr; v.mrd = mrd; v.mwr = mwr;
        v.exp = {urr, urd, uwr, mrv, mra, mwv, mwa, mwd, cnt};
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.up_read_valid    = 1'b0;
        bus.up_read_address  = 8'h00;
        bus.up_write_valid   = 1'b0;
        bus.up_write_address = 8'h00;
        bus.up_write_data    = 8'h00;
        bus.mem_read_ready   = 1'b0;
        bus.mem_read_data    = 8'h00;
    endtask

    // Requester holds valid through the ack cycle and drops it after that edge.
    task automatic do_write(input logic [7:0] a, input logic [7:0] d, input int budget);
        logic seen;
        seen = 1'b0;
        @(negedge clk);
        bus.up_write_valid   = 1'b1;
        bus.up_write_address = a;
        bus.up_write_data    = d;
        for (int i = 0; i < budget && !seen; i++) begin
            tick();
            if (bus.up_write_ready) seen = 1'b1;
        end
        check("write_ack", 64'(seen), 64'd1);
        $display("write a=%h d=%h acked=%0d count=%0d", a, d, seen, bus.wbuf_count);
        tick();
        bus.up_write_valid = 1'b0;
    endtask

    task automatic wait_read(input int budget, output logic ok, output logic [7:0] data);
        ok   = 1'b0;
        data = 8'h00;
        for (int i = 0; i < budget && !ok; i++) begin
            tick();
            if (bus.up_read_ready) begin
                ok   = 1'b1;
                data = bus.up_read_data;
            end
        end
        $display("read a=%h done=%0d data=%h", bus.up_read_address, ok, data);
        tick();
        bus.up_read_valid = 1'b0;
    endtask

    initial begin
        logic       ok;
        logic [7:0] rdata;
        logic       any_ack;

        idle_inputs();
        bus.mem_write_ready = 1'b1;

        // Write 0x10=0x5A with memory always ready
        add(0,8'h00, 1,8'h10,8'h5A, 0,8'h00,1,  0,8'h00,1, 0,8'h00, 0,8'h00,8'h00, 3'd1);
        add(0,8'h00, 1,8'h10,8'h5A, 0,8'h00,1,  0,8'h00,0, 0,8'h00, 1,8'h10,8'h5A, 3'd1);
        add(0,8'h00, 0,8'h00,8'h00, 0,8'h00,1,  0,8'h00,0, 0,8'h00, 0,8'h10,8'h5A, 3'd0);
        add(0,8'h00, 0,8'h00,8'h00, 0,8'h00,1,  0,8'h00,0, 0,8'h00, 0,8'h10,8'h5A, 3'd0);
        // Read miss 0x20, memory answers 0x77 on the third request cycle
        add(1,8'h20, 0,8'h00,8'h00, 0,8'h00,1,  0,8'h00,0, 1,8'h20, 0,8'h10,8'h5A, 3'd0);
        add(1,8'h20, 0,8'h00,8'h00, 0,8'h00,1,  0,8'h00,0, 1,8'h20, 0,8'h10,8'h5A, 3'd0);
        add(1,8'h20, 0,8'h00,8'h00, 0,8'h00,1,  0,8'h00,0, 1,8'h20, 0,8'h10,8'h5A, 3'd0);
        add(1,8'h20, 0,8'h00,8'h00, 1,8'h77,1,  0,8'h00,0, 0,8'h20, 0,8'h10,8'h5A, 3'd0);
        add(1,8'h20, 0,8'h00,8'h00, 0,8'h00,1,  1,8'h77,0, 0,8'h20, 0,8'h10,8'h5A, 3'd0);
        add(1,8'h20, 0,8'h00,8'h00, 0,8'h00,1,  0,8'h77,0, 0,8'h20, 0,8'h10,8'h5A, 3'd0);
        add(0,8'h00, 0,8'h00,8'h00, 0,8'h00,1,  0,8'h77,0, 0,8'h20, 0,8'h10,8'h5A, 3'd0);
        // Same-cycle read 0x40 and write 0x50=0x33: write first, read next
        add(1,8'h40, 1,8'h50,8'h33, 0,8'h00,1,  0,8'h77,1, 0,8'h20, 0,8'h10,8'h5A, 3'd1);
        add(1,8'h40, 1,8'h50,8'h33, 0,8'h00,1,  0,8'h77,0, 1,8'h40, 0,8'h10,8'h5A, 3'd1);
        add(1,8'h40, 0,8'h00,8'h00, 1,8'h9C,1,  0,8'h77,0, 0,8'h40, 0,8'h10,8'h5A, 3'd1);
        add(1,8'h40, 0,8'h00,8'h00, 0,8'h00,1,  1,8'h9C,0, 0,8'h40, 0,8'h10,8'h5A, 3'd1);
        add(1,8'h40, 0,8'h00,8'h00, 0,8'h00,1,  0,8'h9C,0, 0,8'h40, 1,8'h50,8'h33, 3'd1);
        add(0,8'h00, 0,8'h00,8'h00, 0,8'h00,1,  0,8'h9C,0, 0,8'h40, 0,8'h50,8'h33, 3'd0);

        repeat (3) tick();
        check("reset_outputs", 64'(outs()), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        foreach (vecs[k]) begin
            @(negedge clk);
            bus.up_read_valid    = vecs[k].rv;
            bus.up_read_address  = vecs[k].ra;
            bus.up_write_valid   = vecs[k].wv;
            bus.up_write_address = vecs[k].wa;
            bus.up_write_data    = vecs[k].wd;
            bus.mem_read_ready   = vecs[k].mrr;
            bus.mem_read_data    = vecs[k].mrd;
            bus.mem_write_ready  = vecs[k].mwr;
            tick();
            $display("vec %0d outs=%h", k, outs());
            check($sformatf("vec%0d", k), 64'(outs()), 64'(vecs[k].exp));
        end
        @(negedge clk);
        idle_inputs();

        // Two writes to 0x30 held in the buffer; read 0x30 forwards the younger one
        bus.mem_write_ready = 1'b0;
        mem_wr_log.delete();
        mrv_cycles = 0;
        do_write(8'h30, 8'h11, 1);
        do_write(8'h30, 8'h22, 1);
        check("t3_count2", 64'(bus.wbuf_count), 64'd2);
        check("t3_stuck_head", 64'({bus.mem_write_valid, bus.mem_write_address, bus.mem_write_data}),
              64'({1'b1, 8'h30, 8'h11}));
        @(negedge clk);
        bus.up_read_valid   = 1'b1;
        bus.up_read_address = 8'h30;
        repeat (3) tick();
        check("t3_read_waits_write", 64'(bus.up_read_ready), 64'd0);
        @(negedge clk);
        bus.mem_write_ready = 1'b1;
        tick();
        bus.mem_write_ready = 1'b0;
        wait_read(8, ok, rdata);
        check("t3_fwd_done", 64'(ok), 64'd1);
        check("t3_fwd_data", 64'(rdata), 64'h22);
        check("t3_no_mem_read", 64'(mrv_cycles), 64'd0);
        check("t3_count_after_fwd", 64'(bus.wbuf_count), 64'd1);
        @(negedge clk);
        bus.mem_write_ready = 1'b1;
        for (int i = 0; i < 20 && bus.wbuf_count != 0; i++) tick();
        check("t3_drain_len", 64'(mem_wr_log.size()), 64'd2);
        check("t3_drain0", 64'((mem_wr_log.size() > 0) ? mem_wr_log[0] : 16'hFFFF), 64'h3011);
        check("t3_drain1", 64'((mem_wr_log.size() > 1) ? mem_wr_log[1] : 16'hFFFF), 64'h3022);

        // Five writes against a stalled memory: fifth ack waits for the first drain
        @(negedge clk);
        bus.mem_write_ready = 1'b0;
        mem_wr_log.delete();
        peak_count = 0;
        for (int i = 0; i < 4; i++) do_write(8'hA0 + 8'(i), 8'h01 + 8'(i), 1);
        check("t4_full_count", 64'(bus.wbuf_count), 64'd4);
        @(negedge clk);
        bus.up_write_valid   = 1'b1;
        bus.up_write_address = 8'hA4;
        bus.up_write_data    = 8'h05;
        any_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus.up_write_ready) any_ack = 1'b1;
        end
        check("t4_no_ack_when_full", 64'(any_ack), 64'd0);
        @(negedge clk);
        bus.mem_write_ready = 1'b1;
        tick();
        bus.mem_write_ready = 1'b0;
        $display("write a=a4 d=05 ack=%0d count=%0d", bus.up_write_ready, bus.wbuf_count);
        check("t4_ack_with_pop", 64'(bus.up_write_ready), 64'd1);
        check("t4_count_stays_full", 64'(bus.wbuf_count), 64'd4);
        tick();
        bus.up_write_valid = 1'b0;
        @(negedge clk);
        bus.mem_write_ready = 1'b1;
        for (int i = 0; i < 40 && bus.wbuf_count != 0; i++) tick();
        check("t4_drain_len", 64'(mem_wr_log.size()), 64'd5);
        for (int i = 0; i < 5; i++)
            check($sformatf("t4_drain%0d", i),
                  64'((mem_wr_log.size() > i) ? mem_wr_log[i] : 16'hFFFF),
                  64'({8'hA0 + 8'(i), 8'h01 + 8'(i)}));
        check("t4_peak_count", 64'(peak_count), 64'd4);

        // Reset while a read miss is outstanding and two writes are buffered
        @(negedge clk);
        bus.mem_write_ready  = 1'b0;
        bus.up_read_valid    = 1'b1;
        bus.up_read_address  = 8'h70;
        bus.up_write_valid   = 1'b1;
        bus.up_write_address = 8'h60;
        bus.up_write_data    = 8'h01;
        tick();
        check("t6_wr1_ack", 64'(bus.up_write_ready), 64'd1);
        check("t6_read_deferred", 64'(bus.mem_read_valid), 64'd0);
        tick();
        bus.up_write_valid = 1'b0;
        check("t6_read_issued", 64'({bus.mem_read_valid, bus.mem_read_address}), 64'({1'b1, 8'h70}));
        do_write(8'h61, 8'h02, 1);
        check("t6_two_buffered", 64'({bus.mem_read_valid, bus.wbuf_count}), 64'({1'b1, 3'd2}));
        @(negedge clk);
        reset = 1'b1;
        bus.up_read_valid = 1'b0;
        mem_wr_log.delete();
        #1;
        check("t6_async_reset", 64'(outs()), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        bus.mem_write_ready = 1'b1;
        repeat (10) tick();
        check("t6_no_late_writes", 64'(mem_wr_log.size()), 64'd0);
        check("t6_idle_after_reset", 64'(outs()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
